// File: rtl/mod107_pkg.sv
// rtl/mod107_pkg.sv - shared constants, FSM state type and chunk-weight helper
package mod107_pkg;

    localparam int MOD     = 107;
    localparam int MULT    = 100;
    localparam int CHUNK_W = 6;
    localparam int RES_W   = 7;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    // (2^(chunk_w*idx) * mult) mod modulus, built by repeated doubling so ints never overflow
    function automatic int chunk_weight(int idx, int chunk_w, int mult, int modulus);
        int w;
        w = mult % modulus;
        for (int b = 0; b < idx * chunk_w; b++) begin
            w = (w * 2) % modulus;
        end
        return w;
    endfunction

endpackage

// File: rtl/mod107_chunk_lut.sv
// rtl/mod107_chunk_lut.sv - combinational (chunk index, chunk value) -> scaled residue table
module mod107_chunk_lut #(
    parameter int CHUNK_W = mod107_pkg::CHUNK_W,
    parameter int IDX_W   = 3,
    parameter int MOD     = mod107_pkg::MOD,
    parameter int MULT    = mod107_pkg::MULT,
    parameter int RES_W   = mod107_pkg::RES_W
) (
    input  logic [IDX_W-1:0]   idx,
    input  logic [CHUNK_W-1:0] chunk,
    output logic [RES_W-1:0]   res
);
    import mod107_pkg::*;

    localparam int DEPTH = 2 ** (IDX_W + CHUNK_W);

    logic [RES_W-1:0] lut_mem [DEPTH];

    for (genvar i = 0; i < 2 ** IDX_W; i++) begin : g_idx
        localparam int WEIGHT = chunk_weight(i, CHUNK_W, MULT, MOD);
        for (genvar c = 0; c < 2 ** CHUNK_W; c++) begin : g_chunk
            assign lut_mem[i * (2 ** CHUNK_W) + c] = RES_W'((c * WEIGHT) % MOD);
        end
    end

    assign res = lut_mem[{idx, chunk}];

endmodule

// File: rtl/mod107_serial_scaler.sv
// rtl/mod107_serial_scaler.sv - serial (op * MULT) mod MOD using one shared chunk-residue lookup
module mod107_serial_scaler #(
    parameter int IN_WIDTH   = 48,
    parameter int CHUNK_W    = mod107_pkg::CHUNK_W,
    parameter int MOD        = mod107_pkg::MOD,
    parameter int MULT       = mod107_pkg::MULT,
    parameter int RES_W      = mod107_pkg::RES_W,
    parameter int EARLY_EXIT = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_WIDTH-1:0] in_op,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RES_W-1:0]    out_res,
    output logic                busy
);
    import mod107_pkg::*;

    localparam int NCH   = IN_WIDTH / CHUNK_W;
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

    state_e              state_q, state_d;
    logic [IN_WIDTH-1:0] shreg_q, shreg_d;
    logic [RES_W-1:0]    acc_q, acc_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [RES_W-1:0]    out_res_q, out_res_d;
    logic                out_valid_q, out_valid_d;

    logic [RES_W-1:0]    lut_res;
    logic [RES_W:0]      sum;
    logic [RES_W-1:0]    acc_next;
    logic [IN_WIDTH-1:0] shreg_shift;
    logic                last_step;

    mod107_chunk_lut #(
        .CHUNK_W (CHUNK_W),
        .IDX_W   (IDX_W),
        .MOD     (MOD),
        .MULT    (MULT),
        .RES_W   (RES_W)
    ) u_lut (
        .idx   (idx_q),
        .chunk (shreg_q[CHUNK_W-1:0]),
        .res   (lut_res)
    );

    // acc and lut_res are both below MOD, so one conditional subtract fully reduces the sum
    always_comb begin
        sum         = {1'b0, acc_q} + {1'b0, lut_res};
        acc_next    = (sum >= (RES_W+1)'(MOD)) ? RES_W'(sum - (RES_W+1)'(MOD)) : sum[RES_W-1:0];
        shreg_shift = shreg_q >> CHUNK_W;
        last_step   = (idx_q == IDX_W'(NCH - 1)) ||
                      ((EARLY_EXIT != 0) && (shreg_shift == '0));
    end

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        out_res_d   = out_res_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shreg_d = in_op;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d   = acc_next;
                shreg_d = shreg_shift;
                idx_d   = idx_q + IDX_W'(1);
                if (last_step) begin
                    out_res_d   = acc_next;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            out_res_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            out_res_q   <= out_res_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_res   = out_res_q;

endmodule

// File: tb/tb_mod107_serial_scaler.sv
// tb/tb_mod107_serial_scaler.sv - randomized self-checking bench for both EARLY_EXIT builds
module tb_mod107_serial_scaler;

    localparam int W = 48;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid  [2];
    logic         in_ready  [2];
    logic [W-1:0] in_op     [2];
    logic         out_valid [2];
    logic         out_ready [2];
    logic [6:0]   out_res   [2];
    logic         busy      [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mod107_serial_scaler #(.EARLY_EXIT(0)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_op(in_op[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_res(out_res[0]),
        .busy(busy[0])
    );

    mod107_serial_scaler #(.EARLY_EXIT(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_op(in_op[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_res(out_res[1]),
        .busy(busy[1])
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint ref_res(input logic [W-1:0] op);
        longint unsigned v;
        v = longint'(op) * 100;
        return longint'(v % 107);
    endfunction

    function automatic int ref_lat(input int u, input logic [W-1:0] op);
        int k;
        if (u == 0) return 9;
        k = 1;
        for (int i = 0; i < 8; i++) begin
            if (((op >> (6 * i)) & 48'd63) != 0) k = i + 1;
        end
        return k + 1;
    endfunction

    function automatic logic [W-1:0] rand_op();
        logic [W-1:0] op;
        int k;
        op = W'({$urandom, $urandom});
        case ($urandom_range(0, 3))
            0: begin
                k = $urandom_range(0, 7);
                op = op & ((W'(1) << (6 * k)) - W'(1));
            end
            1: op = (op / 107) * 107;
            2: op = W'($urandom_range(0, 300));
            default: ;
        endcase
        return op;
    endfunction

    task automatic run_op(input int u, input logic [W-1:0] op, input int hold, input string tag);
        int   cyc;
        logic saw_ready;
        @(negedge clk);
        check({tag, "/idle_in_ready"}, in_ready[u], 1);
        out_ready[u] = (hold == 0);
        in_valid[u]  = 1'b1;
        in_op[u]     = op;
        @(negedge clk);
        in_valid[u] = 1'b0;
        in_op[u]    = W'({$urandom, $urandom});
        cyc = 1;
        saw_ready = 1'b0;
        while (!out_valid[u] && cyc < 40) begin
            if (in_ready[u] || !busy[u]) saw_ready = 1'b1;
            @(negedge clk);
            cyc++;
        end
        check({tag, "/latency"}, cyc, ref_lat(u, op));
        check({tag, "/res"}, out_res[u], ref_res(op));
        check({tag, "/busy_no_ready"}, saw_ready | in_ready[u], 0);
        for (int i = 0; i < hold; i++) begin
            in_valid[u] = 1'b1;
            in_op[u]    = W'({$urandom, $urandom});
            @(negedge clk);
            check({tag, "/hold_res"}, out_res[u], ref_res(op));
            check({tag, "/hold_valid"}, out_valid[u], 1);
            check({tag, "/hold_busy"}, busy[u], 1);
            check({tag, "/hold_in_ready"}, in_ready[u], 0);
        end
        in_valid[u]  = 1'b0;
        out_ready[u] = 1'b1;
        @(negedge clk);
        check({tag, "/after_valid"}, out_valid[u], 0);
        check({tag, "/after_in_ready"}, in_ready[u], 1);
        check({tag, "/after_busy"}, busy[u], 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1);
    end

    initial begin
        logic saw_valid;
        for (int u = 0; u < 2; u++) begin
            in_valid[u]  = 1'b0;
            in_op[u]     = '0;
            out_ready[u] = 1'b1;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check("reset/in_ready", in_ready[u], 0);
            check("reset/out_valid", out_valid[u], 0);
            check("reset/out_res", out_res[u], 0);
            check("reset/busy", busy[u], 0);
        end
        rst = 1'b0;
        #1;
        check("post_reset/in_ready", in_ready[0], 1);

        run_op(0, 48'd1, 0, "op1");
        run_op(0, 48'd64, 0, "op64");
        run_op(0, 48'd1000, 0, "op1000");
        run_op(0, 48'd107, 0, "op107");
        run_op(0, 48'd108, 0, "op108");
        run_op(0, 48'd1000, 5, "backpressure");

        @(negedge clk);
        in_valid[0] = 1'b1;
        in_op[0]    = 48'd1000;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset/busy", busy[0], 0);
        saw_valid = 1'b0;
        repeat (15) begin
            if (out_valid[0]) saw_valid = 1'b1;
            @(negedge clk);
        end
        check("midreset/no_output", saw_valid, 0);
        run_op(0, 48'd64, 0, "post_midreset");

        run_op(1, 48'd1, 0, "ee_op1");
        run_op(1, 48'd0, 0, "ee_op0");
        run_op(1, 48'h8000_0000_0000, 0, "ee_msb");
        run_op(1, 48'd1000, 2, "ee_op1000");

        fork
            begin
                for (int i = 0; i < 3000; i++) run_op(0, rand_op(), $urandom_range(0, 2), "rand0");
            end
            begin
                for (int i = 0; i < 3000; i++) run_op(1, rand_op(), $urandom_range(0, 2), "rand1");
            end
        join

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
